// File: rtl/cpu_defs.sv
// Shared CPU definitions: reset/exception vector defaults and the fetch FSM encoding.
package cpu_defs;

    localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'hbfc00380;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    // Instruction addresses must be word aligned; anything else raises AdEL.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-port and decode-side handshake bundle of the fetch sequencer.
interface fetch_pc_ctrl_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adel;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output out_valid, out_pc, out_inst, out_adel,
        input  out_ready
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  out_valid, out_pc, out_inst, out_adel,
        output out_ready
    );

endinterface

// File: rtl/fetch_target_mux.sv
// Redirect priority select: exception > eret > branch/jump.
module fetch_target_mux #(
    parameter logic [31:0] EXC_VEC = 32'hbfc00380
) (
    input  logic        exc_valid,
    input  logic        eret_valid,
    input  logic [31:0] epc,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        redir,
    output logic [31:0] target
);

    always_comb begin
        redir = exc_valid | eret_valid | br_valid;
        if (exc_valid) begin
            target = EXC_VEC;
        end else if (eret_valid) begin
            target = epc;
        end else begin
            target = br_target;
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one fetch at a time and
// buffers the returned instruction for decode.
module fetch_pc_ctrl
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            exc_valid,
    input  logic            eret_valid,
    input  logic [31:0]     epc,
    input  logic            br_valid,
    input  logic [31:0]     br_target,
    fetch_pc_ctrl_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         cancel_q, cancel_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  out_pc_q, out_pc_d;
    logic [31:0]  out_inst_q, out_inst_d;
    logic         out_adel_q, out_adel_d;
    logic         req;
    logic         redir;
    logic [31:0]  target;

    fetch_target_mux #(
        .EXC_VEC (EXC_VEC)
    ) u_target_mux (
        .exc_valid  (exc_valid),
        .eret_valid (eret_valid),
        .epc        (epc),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .redir      (redir),
        .target     (target)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            cancel_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= RESET_PC;
            out_inst_q  <= 32'h0;
            out_adel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cancel_q    <= cancel_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_adel_q  <= out_adel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cancel_d    = cancel_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_adel_d  = out_adel_q;
        req         = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;

            ST_REQ: begin
                req = !is_misaligned(pc_q);
                // A redirect always lands in pc_q; if the old address was accepted
                // in the same cycle its returning data must be discarded.
                if (redir) begin
                    pc_d = target;
                    if (req && bus.inst_addr_ok) begin
                        cancel_d = 1'b1;
                        state_d  = ST_WAIT;
                    end
                end else if (!req) begin
                    out_valid_d = 1'b1;
                    out_adel_d  = 1'b1;
                    out_inst_d  = 32'h0;
                    out_pc_d    = pc_q;
                    state_d     = ST_HOLD;
                end else if (bus.inst_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (bus.inst_data_ok) begin
                    if (redir) begin
                        pc_d     = target;
                        cancel_d = 1'b0;
                        state_d  = ST_REQ;
                    end else if (cancel_q) begin
                        cancel_d = 1'b0;
                        state_d  = ST_REQ;
                    end else begin
                        out_valid_d = 1'b1;
                        out_adel_d  = 1'b0;
                        out_inst_d  = bus.inst_rdata;
                        out_pc_d    = pc_q;
                        state_d     = ST_HOLD;
                    end
                end else if (redir) begin
                    pc_d     = target;
                    cancel_d = 1'b1;
                end
            end

            ST_HOLD: begin
                // Redirect squashes the held instruction even if decode accepts it.
                if (redir) begin
                    out_valid_d = 1'b0;
                    out_adel_d  = 1'b0;
                    pc_d        = target;
                    state_d     = ST_REQ;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_adel_d  = 1'b0;
                    pc_d        = pc_q + 32'd4;
                    state_d     = ST_REQ;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.inst_req  = req;
    assign bus.inst_addr = pc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_adel  = out_adel_q;

endmodule
